// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared widths, default base address and responder FSM states
package mem_bus_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'hBFC00000;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} resp_state_t;
endpackage

// File: rtl/byte_ram.sv
// byte_ram: synchronous-read 32-bit RAM with per-byte write enables
module byte_ram
  import mem_bus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [BE_W-1:0]              be,
  input  logic [$clog2(MEM_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);
  logic [DATA_W-1:0] mem [MEM_WORDS];
  always_ff @(posedge clk) begin
    rdata <= mem[idx];
    for (int i = 0; i < BE_W; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: wait-stated single-word memory responder with sticky error flag
module avalon_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              err
);
  localparam int IW = $clog2(MEM_WORDS);
  resp_state_t state, state_n;
  logic [3:0] cnt;
  logic [IW-1:0] lat_idx;
  logic [BE_W-1:0] be_q;
  logic [DATA_W-1:0] wd_q, hold, ram_rdata;
  logic op_rd, bad_q;
  logic [31:0] off;
  logic req, bad_in, abort;
  assign off = address - BASE_ADDR;
  assign req = read | write;
  assign bad_in = address[1:0] != 2'b00 || {2'b00, off[31:2]} >= 32'(MEM_WORDS);
  assign abort = !req || read != op_rd;
  assign waitrequest = state != ACK;
  assign readdata = (state == ACK && op_rd) ? (bad_q ? '0 : ram_rdata) : hold;
  always_comb begin
    state_n = state == IDLE ? (req ? (WAIT_CYCLES > 0 ? WAIT : ACK) : IDLE)
            : state == WAIT ? (abort ? IDLE : cnt == 4'd1 ? ACK : WAIT)
            : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? state_n : IDLE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
      hold <= '0;
    end else begin
      if (state == IDLE && req) begin
        lat_idx <= off[IW+1:2];
        op_rd <= read;
        be_q <= byteenable;
        wd_q <= writedata;
        bad_q <= bad_in;
        cnt <= 4'(WAIT_CYCLES);
        err <= err | bad_in | (read & write);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (abort) err <= 1'b1;
      end
      if (state == ACK && op_rd) hold <= readdata;
    end
  end
  // the read is issued on the edge entering ACK, which from IDLE uses the live address
  byte_ram #(.MEM_WORDS(MEM_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk),
    .we(state == ACK && !op_rd && !bad_q && reset),
    .be(be_q),
    .idx(state == IDLE ? off[IW+1:2] : lat_idx),
    .wdata(wd_q),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb_avalon_mem_responder: directed checks of wait states, byte lanes, errors, abort and reset
module tb_avalon_mem_responder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset;
  logic [31:0] a_address, b_address, a_wd, b_wd, a_rd, b_rd;
  logic a_read, a_write, b_read, b_write, a_wr, b_wr, a_err, b_err;
  logic [3:0] a_be, b_be;
  int checks = 0, errors = 0;
  avalon_mem_responder #(.WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .address(a_address), .read(a_read), .write(a_write),
    .byteenable(a_be), .writedata(a_wd), .waitrequest(a_wr), .readdata(a_rd), .err(a_err));
  avalon_mem_responder #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .address(b_address), .read(b_read), .write(b_write),
    .byteenable(b_be), .writedata(b_wd), .waitrequest(b_wr), .readdata(b_rd), .err(b_err));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic r, input logic w, input logic [31:0] ad, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat, output logic [7:0] pat);
    a_read = r; a_write = w; a_address = ad; a_be = be; a_wd = wd;
    lat = -1; rd = 'x; pat = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pat = {pat[6:0], a_wr};
      if (!a_wr) begin rd = a_rd; lat = i; break; end
    end
    @(posedge clk); #1;
    a_read = 0; a_write = 0;
  endtask
  task automatic wr_a(input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] rd; int lat; logic [7:0] pat;
    xfer(0, 1, ad, be, wd, rd, lat, pat);
    chk("write_latency", 32'(lat), 32'd3);
  endtask
  task automatic rd_a(input string tag, input logic [31:0] ad, input logic [31:0] exp);
    logic [31:0] rd; int lat; logic [7:0] pat;
    xfer(1, 0, ad, 4'h0, '0, rd, lat, pat);
    chk(tag, rd, exp);
  endtask
  task automatic pulse_reset;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask
  initial begin
    logic [31:0] rd, rd0, rd1;
    int lat, lows;
    logic [7:0] pat;
    reset = 0;
    {a_read, a_write, b_read, b_write} = '0;
    a_address = '0; b_address = '0; a_be = '0; b_be = '0; a_wd = '0; b_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_waitrequest", 32'(a_wr), 32'd1);
    chk("reset_readdata", a_rd, 32'h0);
    chk("reset_err", 32'(a_err), 32'd0);
    @(posedge clk); #1;
    reset = 1;
    // zero-wait instance: two writes then two reads with read held continuously
    b_write = 1; b_be = 4'hF; b_address = 32'hBFC00000; b_wd = 32'h11111111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_address = 32'hBFC00004; b_wd = 32'h22222222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_write = 0; b_read = 1; b_address = 32'hBFC00000;
    pat = '0; rd0 = 'x; rd1 = 'x;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = {pat[6:0], b_wr};
      if (i == 1) begin rd0 = b_rd; b_address = 32'hBFC00004; end
      if (i == 3) rd1 = b_rd;
    end
    @(posedge clk); #1;
    b_read = 0;
    chk("b2b_pattern", 32'(pat[3:0]), 32'hA);
    chk("b2b_word0", rd0, 32'h11111111);
    chk("b2b_word1", rd1, 32'h22222222);
    // two-wait instance
    wr_a(32'hBFC00000, 4'hF, 32'h24020005);
    wr_a(32'hBFC00004, 4'hF, 32'h11223344);
    wr_a(32'hBFC00008, 4'hF, 32'hCAFEF00D);
    xfer(1, 0, 32'hBFC00000, 4'h0, '0, rd, lat, pat);
    chk("read_pattern", 32'(pat[3:0]), 32'hE);
    chk("read_latency", 32'(lat), 32'd3);
    chk("read_word0", rd, 32'h24020005);
    @(negedge clk);
    chk("readdata_held", a_rd, 32'h24020005);
    @(posedge clk); #1;
    wr_a(32'hBFC00004, 4'b0101, 32'hAABBCCDD);
    rd_a("byteenable_merge", 32'hBFC00004, 32'h11BB33DD);
    chk("no_err_yet", 32'(a_err), 32'd0);
    xfer(1, 0, 32'hBFC00002, 4'h0, '0, rd, lat, pat);
    chk("misaligned_readdata", rd, 32'h0);
    chk("misaligned_latency", 32'(lat), 32'd3);
    chk("misaligned_err", 32'(a_err), 32'd1);
    wr_a(32'h00000000, 4'hF, 32'hFFFFFFFF);
    wr_a(32'hBFC04000, 4'hF, 32'hEEEEEEEE);
    rd_a("out_of_range_no_write", 32'hBFC00000, 32'h24020005);
    chk("err_sticky", 32'(a_err), 32'd1);
    xfer(1, 1, 32'hBFC00004, 4'hF, 32'h0, rd, lat, pat);
    chk("both_high_reads", rd, 32'h11BB33DD);
    rd_a("both_high_no_write", 32'hBFC00004, 32'h11BB33DD);
    pulse_reset();
    @(negedge clk);
    chk("reset_clears_err", 32'(a_err), 32'd0);
    chk("reset_clears_readdata", a_rd, 32'h0);
    @(posedge clk); #1;
    // drop read while stalled
    a_read = 1; a_address = 32'hBFC00000;
    @(posedge clk); #1;
    a_read = 0;
    lows = 0;
    repeat (5) begin
      @(negedge clk);
      if (!a_wr) lows++;
    end
    chk("abort_no_ack", 32'(lows), 32'd0);
    chk("abort_err", 32'(a_err), 32'd1);
    @(posedge clk); #1;
    pulse_reset();
    // reset landing on the ACK of a write must suppress it
    a_write = 1; a_address = 32'hBFC00008; a_be = 4'hF; a_wd = 32'h12345678;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!a_wr) begin lat = i; break; end
    end
    chk("reset_ack_reached", 32'(lat), 32'd3);
    reset = 0;
    @(posedge clk); #1;
    reset = 1; a_write = 0;
    @(negedge clk);
    chk("reset_ack_err", 32'(a_err), 32'd0);
    @(posedge clk); #1;
    rd_a("reset_suppressed_write", 32'hBFC00008, 32'hCAFEF00D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
